shift_add_multiplier: RTL and testbench

- Iterative 32x32 -> 64-bit multiplier for the ALU. Processes one multiplier bit per cycle.
- Sits directly upstream of the existing sixty_four_bit_adder: the block drives the adder's a/b/c_in inputs every cycle and registers its sum as the running product.
- Supports unsigned and signed (two's complement) operands, valid/ready handshakes on both sides, and optional early termination.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/sixty_four_bit_adder.sv | 11 +
 rtl/shift_add_multiplier.sv | 116 +++++++++++
 tb/tb_shift_add_multiplier.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier widths, iteration counter width and FSM states.
package alu_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // |x| when treated as two's complement; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [MULT_W-1:0] mag(input logic [MULT_W-1:0] x, input logic is_signed);
    return (is_signed && x[MULT_W-1]) ? (~x + {{(MULT_W-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/sixty_four_bit_adder.sv
// 64-bit adder with carry-in, shared datapath used by the iterative multiplier.
module sixty_four_bit_adder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum
);

  assign sum = a + b + {63'd0, c_in};

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative 32x32->64 shift-add multiplier, one multiplier bit per cycle,
// with sign handling by magnitude multiply followed by an optional negate pass.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH      = MULT_W,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 op_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  if (WIDTH != MULT_W) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH must be 32, the adder datapath is fixed at 64 bits");
  end

  mult_state_t         state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [MULT_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;

  logic [PROD_W-1:0]   add_a, add_b, add_sum;
  logic                add_cin;

  // NEG reuses the adder as ~prod + 1; every other state feeds the partial-product add.
  always_comb begin
    add_a   = prod_q;
    add_b   = mplier_q[0] ? mcand_q : '0;
    add_cin = 1'b0;
    if (state_q == NEG) begin
      add_a   = ~prod_q;
      add_b   = '0;
      add_cin = 1'b1;
    end
  end

  sixty_four_bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .c_in (add_cin),
    .sum  (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{(PROD_W-MULT_W){1'b0}}, mag(op_a, op_signed)};
          mplier_d = mag(op_b, op_signed);
          prod_d   = '0;
          cnt_d    = '0;
          neg_d    = op_signed & (op_a[MULT_W-1] ^ op_b[MULT_W-1]);
          state_d  = RUN;
        end
      end
      RUN: begin
        prod_d   = add_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {CNT_W{1'b1}} || (EARLY_EXIT && mplier_d == '0)) begin
          state_d = neg_q ? NEG : DONE;
        end
      end
      NEG: begin
        prod_d  = add_sum;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed checks of shift_add_multiplier against an arithmetic reference model.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic        out_ready;
  logic        iv0, iv1;
  logic        ir0, ir1, ov0, ov1, busy0, busy1;
  logic [63:0] res0, res1;

  int compared   = 0;
  int mismatched = 0;

  shift_add_multiplier #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .busy(busy0)
  );

  shift_add_multiplier #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ov(input int sel);
    return (sel != 0) ? ov1 : ov0;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel != 0) ? ir1 : ir0;
  endfunction
  function automatic logic [63:0] get_res(input int sel);
    return (sel != 0) ? res1 : res0;
  endfunction

  // Reference: exact product modulo 2^64 from plain signed/unsigned arithmetic.
  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Reference latency in edges after the accept edge until out_valid is seen.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s, input bit ee);
    logic [31:0] mb;
    int iters;
    int bits;
    mb   = (s && b[31]) ? (-b) : b;
    bits = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) bits = i + 1;
    iters = ee ? ((bits == 0) ? 1 : bits) : 32;
    return iters + ((s && (a[31] ^ b[31])) ? 1 : 0);
  endfunction

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    check_int("in_ready_before_accept", int'(get_ir(sel)), 1);
    op_a = a; op_b = b; op_signed = s;
    if (sel != 0) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk);
  endtask

  task automatic finish_op(input int sel, input logic [63:0] exp, input int lat, input int hold);
    int edges;
    logic [63:0] held;
    edges = 0;
    @(negedge clk);
    iv0 = 1'b0; iv1 = 1'b0;
    op_a = $urandom; op_b = $urandom;
    while (!get_ov(sel) && edges < 80) begin
      check_int("in_ready_low_while_busy", int'(get_ir(sel)), 0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_int("latency", edges, lat);
    check64("result", get_res(sel), exp);
    held = get_res(sel);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_int("out_valid_held", int'(get_ov(sel)), 1);
      check64("result_held", get_res(sel), held);
      check_int("in_ready_held_low", int'(get_ir(sel)), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_int("out_valid_after_handshake", int'(get_ov(sel)), 0);
    check_int("in_ready_after_handshake", int'(get_ir(sel)), 1);
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    start_op(sel, a, b, s);
    finish_op(sel, model_prod(a, b, s), model_lat(a, b, s, sel != 0), hold);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0; iv0 = 1'b0; iv1 = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_signed = 1'b0;
    #12;
    check_int("reset_in_ready", int'(ir0), 1);
    check_int("reset_out_valid", int'(ov0), 0);
    check_int("reset_busy", int'(busy0), 0);
    check64("reset_result", res0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'd3, 32'd5, 1'b0, 0);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(0, 32'hFFFF_FFF9, 32'd6, 1'b1, 5);
    run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_op(0, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(1, 32'd3, 32'd5, 1'b0, 0);
    run_op(1, 32'd2, 32'hFFFF_FFFF, 1'b1, 2);
    run_op(1, 32'd0, 32'd0, 1'b0, 0);

    // Reset in the middle of RUN, with a fresh operation queued across the reset release.
    start_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_int("midreset_out_valid", int'(ov0), 0);
    check_int("midreset_busy", int'(busy0), 0);
    check_int("midreset_in_ready", int'(ir0), 1);
    op_a = 32'd12; op_b = 32'd12; op_signed = 1'b0;
    iv0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    finish_op(0, 64'h90, 32, 0);

    for (int n = 0; n < 16; n++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_op(0, ra, rb, rs, int'($urandom_range(0, 2)));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      rs = 1'($urandom_range(0, 1));
      run_op(1, ra, rb, rs, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
